// File: rtl/cdb_pkg.sv
// Shared CDB definitions: default result widths and the tag/wdata entry type
// carried from each execution unit's result queue to the CDB arbiter.
package cdb_pkg;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] wdata;
  } cdb_entry_t;
endpackage

// File: rtl/exu_result_queue.sv
// Per-execution-unit result FIFO sitting in front of the CDB arbiter. The unit
// retires into it whenever there is space; the oldest result is offered on the
// exu2cdb request side until granted. in_rdy and cdb_req come straight from
// registered occupancy so the arbiter can build its grant combinationally.
module exu_result_queue #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = cdb_pkg::TAG_W,
  parameter int DATA_W = cdb_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic [DATA_W-1:0]        in_wdata,
  output logic                     cdb_req,
  input  logic                     cdb_rdy,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_wdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Same layout as cdb_pkg::cdb_entry_t, but sized by this instance's params
  // so a unit with a wider tag or result still fits.
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] wdata;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push, pop;

  assign in_rdy  = (count != CNT_W'(DEPTH));
  assign cdb_req = (count != '0);
  assign push    = in_vld && in_rdy;
  assign pop     = cdb_req && cdb_rdy;

  // Head entry drives the CDB side; it only moves when a grant is consumed.
  assign cdb_tag   = mem[rd_ptr].tag;
  assign cdb_wdata = mem[rd_ptr].wdata;

  // Pointer and occupancy update; flush wins over any push/pop that cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr] <= '{tag: in_tag, wdata: in_wdata};
    end
  end
endmodule

// File: tb/tb_exu_result_queue.sv
// Self-checking bench for exu_result_queue (DEPTH=4). A negedge monitor keeps
// an independent occupancy/ordering model fed by the driven stimulus and checks
// every head presentation against it; scenario tasks add targeted checks.
module tb_exu_result_queue;
  localparam int DEPTH  = 4;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst, flush, in_vld, in_rdy, cdb_req, cdb_rdy;
  logic [TAG_W-1:0]  in_tag, cdb_tag;
  logic [DATA_W-1:0] in_wdata, cdb_wdata;
  logic [2:0]        count;

  int nvec  = 0;
  int nfail = 0;

  exu_result_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_tag(in_tag), .in_wdata(in_wdata),
    .cdb_req(cdb_req), .cdb_rdy(cdb_rdy), .cdb_tag(cdb_tag),
    .cdb_wdata(cdb_wdata), .count(count)
  );

  always #5 clk = ~clk;

  // Scoreboard: expected entries in order, plus model occupancy.
  logic [TAG_W+DATA_W-1:0] sb[$];
  bit mon_en = 1'b0;

  // Monitor: compare DUT state against the model, then advance the model
  // with the inputs that the coming posedge will see.
  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_req, exp_rdy;
      exp_req = (sb.size() != 0);
      exp_rdy = (sb.size() != DEPTH);
      nvec++;
      if (count !== 3'(sb.size())) begin
        nfail++;
        $display("FAIL mon_count: got %0d want %0d at %0t", count, sb.size(), $time);
      end
      nvec++;
      if (cdb_req !== exp_req || in_rdy !== exp_rdy) begin
        nfail++;
        $display("FAIL mon_flags: req=%b rdy=%b want req=%b rdy=%b at %0t",
                 cdb_req, in_rdy, exp_req, exp_rdy, $time);
      end
      if (exp_req) begin
        nvec++;
        if ({cdb_tag, cdb_wdata} !== sb[0]) begin
          nfail++;
          $display("FAIL mon_head: got tag=%h data=%h want tag=%h data=%h at %0t",
                   cdb_tag, cdb_wdata, sb[0][DATA_W+:TAG_W], sb[0][DATA_W-1:0], $time);
        end
      end
      if (rst || flush) begin
        sb.delete();
      end else begin
        if (exp_req && cdb_rdy) void'(sb.pop_front());
        if (in_vld && exp_rdy) sb.push_back({in_tag, in_wdata});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; in_vld = 0; cdb_rdy = 0; in_tag = '0; in_wdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    step(); step();
    rst = 0;
    mon_en = 1'b1;
    nvec++;
    if (count !== 3'd0 || cdb_req !== 1'b0 || in_rdy !== 1'b1) begin
      nfail++;
      $display("FAIL reset_flags: count=%0d req=%b rdy=%b want 0/0/1", count, cdb_req, in_rdy);
    end
    nvec++;
    if (cdb_tag !== 4'd0 || cdb_wdata !== 32'd0) begin
      nfail++;
      $display("FAIL reset_head: tag=%h data=%h want 0/0", cdb_tag, cdb_wdata);
    end
  endtask

  task automatic test_pass_through();
    cdb_rdy = 1; in_vld = 1; in_tag = 4'd3; in_wdata = 32'hDEADBEEF;
    nvec++;
    if (cdb_req !== 1'b0) begin
      nfail++;
      $display("FAIL pass_pre: req=%b want 0", cdb_req);
    end
    step();
    in_vld = 0;
    nvec++;
    if (cdb_req !== 1'b1 || cdb_tag !== 4'd3 || cdb_wdata !== 32'hDEADBEEF) begin
      nfail++;
      $display("FAIL pass_head: req=%b tag=%h data=%h want 1/3/deadbeef", cdb_req, cdb_tag, cdb_wdata);
    end
    step();
    nvec++;
    if (cdb_req !== 1'b0 || count !== 3'd0) begin
      nfail++;
      $display("FAIL pass_after: req=%b count=%0d want 0/0", cdb_req, count);
    end
    cdb_rdy = 0;
  endtask

  task automatic fill(input logic [TAG_W-1:0] first);
    cdb_rdy = 0;
    for (int i = 0; i < DEPTH; i++) begin
      in_vld = 1; in_tag = first + TAG_W'(i); in_wdata = 32'h1111_0000 + 32'(first + TAG_W'(i));
      step();
    end
    in_vld = 0;
  endtask

  task automatic test_fill();
    fill(4'd1);
    nvec++;
    if (count !== 3'd4 || in_rdy !== 1'b0) begin
      nfail++;
      $display("FAIL fill_full: count=%0d rdy=%b want 4/0", count, in_rdy);
    end
    in_vld = 1; in_tag = 4'd5; in_wdata = 32'h5555;
    step();
    in_vld = 0;
    nvec++;
    if (count !== 3'd4 || cdb_tag !== 4'd1) begin
      nfail++;
      $display("FAIL fill_extra: count=%0d head=%h want 4/1", count, cdb_tag);
    end
  endtask

  task automatic test_drain();
    cdb_rdy = 1;
    for (int i = 1; i <= DEPTH; i++) begin
      nvec++;
      if (cdb_req !== 1'b1 || cdb_tag !== 4'(i)) begin
        nfail++;
        $display("FAIL drain_%0d: req=%b tag=%h want 1/%h", i, cdb_req, cdb_tag, 4'(i));
      end
      step();
    end
    nvec++;
    if (cdb_req !== 1'b0) begin
      nfail++;
      $display("FAIL drain_empty: req=%b want 0", cdb_req);
    end
    cdb_rdy = 0;
  endtask

  task automatic test_full_simul();
    fill(4'd5);  // tags 5,6,7,8
    cdb_rdy = 1; in_vld = 1; in_tag = 4'hA; in_wdata = 32'hAAAA;
    nvec++;
    if (in_rdy !== 1'b0) begin
      nfail++;
      $display("FAIL full_rdy: rdy=%b want 0", in_rdy);
    end
    step();
    nvec++;
    if (count !== 3'd3 || in_rdy !== 1'b1) begin
      nfail++;
      $display("FAIL full_pop: count=%0d rdy=%b want 3/1", count, in_rdy);
    end
    in_tag = 4'd9; in_wdata = 32'h9999;
    step();
    in_vld = 0;
    nvec++;
    if (count !== 3'd3) begin
      nfail++;
      $display("FAIL full_pushpop: count=%0d want 3", count);
    end
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (cdb_tag !== 4'(7 + i)) begin
        nfail++;
        $display("FAIL full_order_%0d: tag=%h want %h", i, cdb_tag, 4'(7 + i));
      end
      step();
    end
    nvec++;
    if (cdb_req !== 1'b0) begin
      nfail++;
      $display("FAIL full_empty: req=%b want 0", cdb_req);
    end
    cdb_rdy = 0;
  endtask

  task automatic test_flush();
    cdb_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      in_vld = 1; in_tag = 4'(11 + i); in_wdata = 32'(32'hF00 + i);
      step();
    end
    nvec++;
    if (count !== 3'd3) begin
      nfail++;
      $display("FAIL flush_pre: count=%0d want 3", count);
    end
    flush = 1; in_vld = 1; in_tag = 4'd14; cdb_rdy = 1;
    step();
    flush = 0; in_vld = 0;
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (count !== 3'd0 || cdb_req !== 1'b0) begin
        nfail++;
        $display("FAIL flush_cyc%0d: count=%0d req=%b want 0/0", i, count, cdb_req);
      end
      step();
    end
    cdb_rdy = 0;
  endtask

  task automatic test_back_to_back();
    bit done = 0;
    for (int c = 0; c < 300; c++) begin
      in_vld   = 1'($urandom_range(0, 3) != 0);
      cdb_rdy  = 1'($urandom_range(0, 2) != 0);
      in_tag   = 4'($urandom);
      in_wdata = $urandom;
      step();
    end
    in_vld = 0; cdb_rdy = 1;
    for (int c = 0; c < 10 && !done; c++) begin
      if (count == 0) done = 1;
      else step();
    end
    nvec++;
    if (!done) begin
      nfail++;
      $display("FAIL b2b_drain: count=%0d want 0 within 10 cycles", count);
    end
    cdb_rdy = 0;
  endtask

  task automatic test_mid_reset();
    cdb_rdy = 0;
    in_vld = 1; in_tag = 4'd6; in_wdata = 32'h1234_5678;
    step(); step();
    in_vld = 0; rst = 1;
    step();
    rst = 0;
    nvec++;
    if (count !== 3'd0 || cdb_req !== 1'b0 || cdb_tag !== 4'd0 || cdb_wdata !== 32'd0) begin
      nfail++;
      $display("FAIL mid_reset: count=%0d req=%b tag=%h data=%h want 0/0/0/0",
               count, cdb_req, cdb_tag, cdb_wdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_pass_through();
    test_fill();
    test_drain();
    test_full_simul();
    test_flush();
    test_back_to_back();
    test_mid_reset();
    step();
    mon_en = 1'b0;
    nvec++;
    if (sb.size() != 0) begin
      nfail++;
      $display("FAIL sb_leftover: %0d entries want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/exu_result_queue.md
# exu_result_queue

- Per-execution-unit result buffer between an execution unit (ALU, MDU or LSU) and the CDB arbiter.
- Captures completed results as tag/wdata pairs and holds them in a small FIFO. Presents the oldest one on the exu2cdb request side until the arbiter grants it.
- Decouples unit completion from CDB priority loss: the unit retires a result every cycle while the queue has space, so lower-priority units no longer stall their pipelines when the CDB is busy.

## Interface
Parameters:
- DEPTH, 4, entry count; power of two, ≥2.
- TAG_W, 4, ROB/RS tag width.
- DATA_W, 32, result width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  synchronous discard of all queued entries (mispredict recovery).
- in_vld  in  1  unit presents a result this cycle.
- in_rdy  out  1  queue accepts a result this cycle.
- in_tag  in  TAG_W  destination tag of the presented result.
- in_wdata  in  DATA_W  result value.
- cdb_req  out  1  head entry valid; maps to exu2cdb req.
- cdb_rdy  in  1  arbiter grant; maps to exu2cdb rdy.
- cdb_tag  out  TAG_W  head tag; maps to exu2cdb tag.
- cdb_wdata  out  DATA_W  head value; maps to exu2cdb wdata.
- count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.

## Operation
- Push: in_vld && in_rdy writes {in_tag, in_wdata} at the write pointer, and the write pointer increments.
- Pop: cdb_req && cdb_rdy removes the head, and the read pointer increments.
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. Occupancy is held as a separate counter (count).
- in_rdy = (count != DEPTH). It depends only on registered state, never on cdb_rdy.
- cdb_req = (count != 0). It is a function of registered state only. This is mandatory because the arbiter computes rdy combinationally from the reqs.
- cdb_tag and cdb_wdata are driven from the head entry. They are don't-care when cdb_req = 0, but must be stable while cdb_req = 1 and not granted.
- Push and pop in the same cycle: both pointers advance and count is unchanged.
- When full, a push is not possible (in_rdy = 0); a pop in that cycle leaves count = DEPTH-1.
- When empty, a push sets count = 1; the entry is not visible on cdb_req until the next cycle.
- Flush: pointers and count are set to 0 next cycle. Any push or pop in the flush cycle is discarded. Flush has priority over push and pop.
- Results are never reordered, never dropped (except by flush), and never duplicated.

## Timing
- Reset values: count = 0, cdb_req = 0, in_rdy = 1, pointers = 0. cdb_tag and cdb_wdata = 0 (storage array cleared on reset).
- Latency: a result pushed in cycle N raises cdb_req in N+1. With immediate grant it appears on the arbiter's registered CDB output in N+2.
- Throughput: one push and one pop per cycle.
- A grant is consumed on the same clock edge it is seen. The next entry, or cdb_req = 0, is presented in the following cycle.
- rst asserted mid-operation empties the queue on the next edge, identically to flush, and additionally clears storage.

## Structure
- Shared package cdb_pkg:
  - TAG_W and DATA_W defaults.
  - typedef struct packed {logic [TAG_W-1:0] tag; logic [DATA_W-1:0] wdata;} cdb_entry_t.
- Storage is an inline array of cdb_entry_t flops; no sub-module.
- The top-level instantiates one queue per unit, with the cdb_* ports bound to that unit's exu2cdb_itf.

## Test plan
- Reset then idle: rst for 2 cycles -> count = 0, cdb_req = 0, in_rdy = 1, cdb_tag = 0, cdb_wdata = 0.
- Single pass-through: push tag = 3, wdata = 0xDEADBEEF with cdb_rdy = 1 held -> cdb_req high exactly 1 cycle, the cycle after the push, with tag 3 / 0xDEADBEEF; count returns to 0.
- Fill and backpressure (DEPTH = 4): cdb_rdy = 0, push tags 1,2,3,4 -> count = 4, in_rdy = 0; a 5th in_vld is ignored; head holds tag 1.
- Drain in order: from the full state, set cdb_rdy = 1 -> tags 1,2,3,4 presented on consecutive cycles, then cdb_req = 0.
- Simultaneous push/pop at full: count = 4, cdb_rdy = 1, in_vld = 1 -> in_rdy = 0, so no push. Next cycle count = 3, in_rdy = 1; push tag 9 with grant -> count stays 3, and tag 9 appears after the older entries.
- Flush mid-stream: count = 3 with in_vld = 1 and cdb_rdy = 1 asserted alongside flush -> next cycle count = 0, cdb_req = 0, and none of those tags is ever presented.
